keypad_scan_ctrl: RTL and testbench

- Sequencer for the 4x4 matrix keypad on the stopwatch-calculator board.
- Drives the column lines one-hot in rotation and samples the row lines.
- Debounces press and release, then emits a one-cycle key event with a 4-bit key code.
- Sits between the keypad pins and the calculator/stopwatch control logic. It owns the column drive, so no other block drives COLUMN.

---
 rtl/keypad_scan_ctrl_if.sv | 20 ++
 rtl/keypad_scan_ctrl.sv | 151 +++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_scan_ctrl_if.sv
// Keypad-side and control-side signals of the 4x4 keypad scanner.
// master is the scanner itself; slave is whatever drives scan_en and consumes key events.
interface keypad_scan_ctrl_if;
  logic       scan_en;
  logic [3:0] LINE;
  logic [3:0] COLUMN;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    input  scan_en, LINE,
    output COLUMN, key_code, key_valid, key_held
  );

  modport slave (
    output scan_en, LINE,
    input  COLUMN, key_code, key_valid, key_held
  );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: one-hot column rotation, row sampling,
// press/release debounce and a single-cycle key event with a 4-bit code.
module keypad_scan_ctrl #(
  parameter int DWELL_CYCLES    = 50000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                clk,
  input  logic                rst,
  keypad_scan_ctrl_if.master  kp
);

  localparam int DW = $clog2(DWELL_CYCLES);
  localparam int BW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DWELL_LAST  = DW'(DWELL_CYCLES - 1);
  localparam logic [BW-1:0] STABLE_LAST = BW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DEBOUNCE, HOLD} state_t;

  state_t        r_state;
  logic [3:0]    r_line_meta;
  logic [3:0]    r_line_sync;
  logic [3:0]    r_row;
  logic [3:0]    r_column;
  logic [3:0]    r_key_code;
  logic          r_key_valid;
  logic          r_key_held;
  logic [DW-1:0] r_dwell;
  logic [BW-1:0] r_stable;

  logic [3:0]    w_line;
  logic          w_line_onehot;
  logic [3:0]    w_column_next;
  logic [3:0]    w_key_code;

  function automatic logic [1:0] onehot_to_idx(input logic [3:0] v);
    case (v)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Map index is {row, col}; matches the legend printed on the keypad.
  function automatic logic [3:0] key_code_of(input logic [1:0] row, input logic [1:0] col);
    case ({row, col})
      4'h0: return 4'd1;   4'h1: return 4'd2;   4'h2: return 4'd3;   4'h3: return 4'd10;
      4'h4: return 4'd4;   4'h5: return 4'd5;   4'h6: return 4'd6;   4'h7: return 4'd11;
      4'h8: return 4'd7;   4'h9: return 4'd8;   4'hA: return 4'd9;   4'hB: return 4'd12;
      4'hC: return 4'd15;  4'hD: return 4'd0;   4'hE: return 4'd14;  default: return 4'd13;
    endcase
  endfunction

  assign w_line        = r_line_sync;
  assign w_line_onehot = (w_line != 4'b0) && ((w_line & (w_line - 4'd1)) == 4'b0);
  assign w_column_next = {r_column[2:0], r_column[3]};
  assign w_key_code    = key_code_of(onehot_to_idx(r_row), onehot_to_idx(r_column));

  // NOTE: all state below uses non-blocking assignments so every register
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= SCAN;
      r_line_meta <= 4'b0;
      r_line_sync <= 4'b0;
      r_row       <= 4'b0;
      r_column    <= 4'b0001;
      r_key_code  <= 4'd0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
      r_dwell     <= '0;
      r_stable    <= '0;
    end else begin
      r_line_meta <= kp.LINE;
      r_line_sync <= r_line_meta;
      r_key_valid <= 1'b0;

      if (!kp.scan_en) begin
        r_state    <= IDLE;
        r_column   <= 4'b0;
        r_key_held <= 1'b0;
        r_dwell    <= '0;
        r_stable   <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            r_state  <= SCAN;
            r_column <= 4'b0001;
          end

          SCAN: begin
            if (r_dwell == DWELL_LAST) begin
              r_dwell <= '0;
              // Zero or multiple rows means no key or possible ghosting: move on.
              if (w_line_onehot) begin
                r_row    <= w_line;
                r_stable <= '0;
                r_state  <= DEBOUNCE;
              end else begin
                r_column <= w_column_next;
              end
            end else begin
              r_dwell <= r_dwell + DW'(1);
            end
          end

          DEBOUNCE: begin
            if (w_line == r_row) begin
              if (r_stable == STABLE_LAST) begin
                r_key_valid <= 1'b1;
                r_key_code  <= w_key_code;
                r_key_held  <= 1'b1;
                r_stable    <= '0;
                r_state     <= HOLD;
              end else begin
                r_stable <= r_stable + BW'(1);
              end
            end else begin
              r_stable <= '0;
              r_column <= w_column_next;
              r_state  <= SCAN;
            end
          end

          HOLD: begin
            if (w_line == 4'b0) begin
              if (r_stable == STABLE_LAST) begin
                r_key_held <= 1'b0;
                r_stable   <= '0;
                r_column   <= w_column_next;
                r_state    <= SCAN;
              end else begin
                r_stable <= r_stable + BW'(1);
              end
            end else begin
              r_stable <= '0;
            end
          end

          default: r_state <= SCAN;
        endcase
      end
    end
  end

  assign kp.COLUMN    = r_column;
  assign kp.key_code  = r_key_code;
  assign kp.key_valid = r_key_valid;
  assign kp.key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with a keypad model that returns the
// pressed row only while its column is driven.
module tb_keypad_scan_ctrl;
  localparam int DWELL = 4;
  localparam int DEB   = 8;

  logic clk = 1'b0;
  logic rst;

  keypad_scan_ctrl_if kp ();

  keypad_scan_ctrl #(
    .DWELL_CYCLES   (DWELL),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .kp (kp)
  );

  always #5 clk = ~clk;

  logic       press_active;
  logic [3:0] press_row;
  logic [1:0] press_col;

  assign kp.LINE = (press_active && kp.COLUMN[press_col]) ? press_row : 4'b0;

  int total = 0;
  int bad   = 0;
  int valid_count = 0;
  int vc0;

  always @(posedge clk) if (kp.key_valid === 1'b1) valid_count++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] col_oh(input logic [1:0] c);
    logic [3:0] one;
    one = 4'b0001;
    return one << c;
  endfunction

  task automatic wait_col(input logic [3:0] target);
    int n;
    n = 0;
    while (kp.COLUMN !== target && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) check("col_timeout", {28'b0, kp.COLUMN}, {28'b0, target});
  endtask

  // Returns at the negedge right after the DUT entered DEBOUNCE.
  task automatic press_start(input logic [3:0] row, input logic [1:0] col);
    wait_col(col_oh(col - 2'd1));
    wait_col(col_oh(col));
    press_row    = row;
    press_col    = col;
    press_active = 1'b1;
    repeat (DWELL) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic press_accept(input logic [3:0] row, input logic [1:0] col, input logic [3:0] code);
    press_start(row, col);
    repeat (DEB - 1) @(posedge clk);
    @(negedge clk);
    check("pre_valid", {31'b0, kp.key_valid}, 32'd0);
    @(posedge clk); @(negedge clk);
    check("valid_pulse", {31'b0, kp.key_valid}, 32'd1);
    check("valid_code", {28'b0, kp.key_code}, {28'b0, code});
    check("valid_held", {31'b0, kp.key_held}, 32'd1);
    check("col_frozen", {28'b0, kp.COLUMN}, {28'b0, col_oh(col)});
    @(negedge clk);
    check("valid_single", {31'b0, kp.key_valid}, 32'd0);
    check("held_on", {31'b0, kp.key_held}, 32'd1);
  endtask

  task automatic release_key(input logic [3:0] next_col);
    press_active = 1'b0;
    repeat (DEB + 1) @(posedge clk);
    @(negedge clk);
    check("rel_still_held", {31'b0, kp.key_held}, 32'd1);
    @(posedge clk); @(negedge clk);
    check("rel_held_off", {31'b0, kp.key_held}, 32'd0);
    check("rel_next_col", {28'b0, kp.COLUMN}, {28'b0, next_col});
  endtask

  // Single-cycle bounce reaches the release counter when it holds 6.
  task automatic release_glitch(input logic [3:0] next_col);
    press_active = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    press_active = 1'b1;
    @(posedge clk); @(negedge clk);
    press_active = 1'b0;
    repeat (DEB + 1) @(posedge clk);
    @(negedge clk);
    check("glitch_still_held", {31'b0, kp.key_held}, 32'd1);
    @(posedge clk); @(negedge clk);
    check("glitch_held_off", {31'b0, kp.key_held}, 32'd0);
    check("glitch_next_col", {28'b0, kp.COLUMN}, {28'b0, next_col});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] scan_seq [4];
    scan_seq[0] = 4'b0010; scan_seq[1] = 4'b0100; scan_seq[2] = 4'b1000; scan_seq[3] = 4'b0001;

    rst = 1'b1; press_active = 1'b0; press_row = 4'b0; press_col = 2'd0; kp.scan_en = 1'b1;
    #12;
    check("rst_col", {28'b0, kp.COLUMN}, 32'h1);
    check("rst_valid", {31'b0, kp.key_valid}, 32'd0);
    check("rst_held", {31'b0, kp.key_held}, 32'd0);
    check("rst_code", {28'b0, kp.key_code}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Free-running rotation with no key pressed.
    for (int k = 0; k < 4; k++) begin
      repeat (DWELL - 1) @(posedge clk);
      @(negedge clk);
      check("scan_hold_col", {28'b0, kp.COLUMN}, {28'b0, (k == 0) ? 4'b0001 : scan_seq[k-1]});
      @(posedge clk); @(negedge clk);
      check("scan_step", {28'b0, kp.COLUMN}, {28'b0, scan_seq[k]});
      check("scan_no_held", {31'b0, kp.key_held}, 32'd0);
    end
    check("scan_no_valid", valid_count, 32'd0);

    // Presses and clean releases.
    press_accept(4'b0010, 2'd1, 4'd5);  release_key(4'b0100);
    press_accept(4'b1000, 2'd2, 4'd14); release_key(4'b1000);
    press_accept(4'b1000, 2'd0, 4'd15); release_key(4'b0010);
    press_accept(4'b1000, 2'd3, 4'd13); release_key(4'b0001);

    // Release with a bounce restarts the release count.
    press_accept(4'b0010, 2'd1, 4'd5);  release_glitch(4'b0100);

    // Press bounce on '7' at debounce count 5.
    press_start(4'b0100, 2'd0);
    vc0 = valid_count;
    repeat (3) @(posedge clk);
    @(negedge clk); press_active = 1'b0;
    @(posedge clk); @(negedge clk); press_active = 1'b1;
    @(posedge clk); @(negedge clk);
    check("bounce_frozen", {28'b0, kp.COLUMN}, 32'h1);
    @(posedge clk); @(negedge clk);
    check("bounce_resume", {28'b0, kp.COLUMN}, 32'h2);
    press_active = 1'b0;
    repeat (DEB) @(posedge clk);
    @(negedge clk);
    check("bounce_no_event", valid_count, vc0);
    check("bounce_code_kept", {28'b0, kp.key_code}, 32'd5);

    // Two rows on one column is treated as ghosting.
    wait_col(4'b0001);
    wait_col(4'b0010);
    press_row = 4'b0011; press_col = 2'd1; press_active = 1'b1;
    vc0 = valid_count;
    repeat (DWELL) @(posedge clk);
    @(negedge clk);
    check("ghost_skip", {28'b0, kp.COLUMN}, 32'h4);
    press_active = 1'b0;
    repeat (DWELL) @(posedge clk);
    @(negedge clk);
    check("ghost_no_event", valid_count, vc0);

    // scan_en low parks the block during HOLD.
    press_accept(4'b0001, 2'd3, 4'd10);
    kp.scan_en = 1'b0;
    @(posedge clk); @(negedge clk);
    check("idle_col", {28'b0, kp.COLUMN}, 32'h0);
    check("idle_held", {31'b0, kp.key_held}, 32'd0);
    check("idle_code", {28'b0, kp.key_code}, 32'd10);
    press_active = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("idle_park", {28'b0, kp.COLUMN}, 32'h0);
    kp.scan_en = 1'b1;
    @(posedge clk); @(negedge clk);
    check("idle_restart", {28'b0, kp.COLUMN}, 32'h1);
    repeat (DWELL) @(posedge clk);
    @(negedge clk);
    check("idle_rotate", {28'b0, kp.COLUMN}, 32'h2);

    // Asynchronous reset during DEBOUNCE of 'B'.
    press_start(4'b0010, 2'd3);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_deb_col", {28'b0, kp.COLUMN}, 32'h1);
    check("arst_deb_held", {31'b0, kp.key_held}, 32'd0);
    check("arst_deb_code", {28'b0, kp.key_code}, 32'd0);
    check("arst_deb_valid", {31'b0, kp.key_valid}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    repeat (3 * DWELL + DWELL + DEB - 1) @(posedge clk);
    @(negedge clk);
    check("arst_no_early", {31'b0, kp.key_valid}, 32'd0);
    @(posedge clk); @(negedge clk);
    check("arst_fresh_valid", {31'b0, kp.key_valid}, 32'd1);
    check("arst_fresh_code", {28'b0, kp.key_code}, 32'd11);

    // Asynchronous reset during HOLD.
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_hold_col", {28'b0, kp.COLUMN}, 32'h1);
    check("arst_hold_held", {31'b0, kp.key_held}, 32'd0);
    check("arst_hold_code", {28'b0, kp.key_code}, 32'd0);
    press_active = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    vc0 = valid_count;
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("arst_hold_no_event", valid_count, vc0);
    check("arst_hold_code_kept", {28'b0, kp.key_code}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
